// File: rtl/out_bcd_converter_if.sv
// out_bcd_converter_if: binary word in, packed BCD result and status out.
// With SEVEN_SEG_EN defined the bundle also carries the active-low segment field.
interface out_bcd_converter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DIGITS = 5
);
    logic [DATA_WIDTH-1:0] in;
    logic [4*DIGITS-1:0] bcd;
    logic valid;
    logic busy;
    logic done;
`ifdef SEVEN_SEG_EN
    logic [7*DIGITS-1:0] seg;
`endif
    modport master (
        output in,
        input bcd, valid, busy, done
`ifdef SEVEN_SEG_EN
        , input seg
`endif
    );
    modport slave (
        input in,
        output bcd, valid, busy, done
`ifdef SEVEN_SEG_EN
        , output seg
`endif
    );
endinterface

// File: rtl/out_bcd_converter.sv
// out_bcd_converter: converts each new CPU output word to packed BCD, one double-dabble bit per clock.
// Define SEVEN_SEG_EN to add registered active-low 7-segment decoders loaded alongside bcd.
module out_bcd_converter #(
    parameter int DATA_WIDTH = 16,
    parameter int DIGITS = 5
) (
    input logic clk,
    input logic rst_n,
    out_bcd_converter_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, next;
    logic [DATA_WIDTH-1:0] last_val, shreg;
    logic [4*DIGITS-1:0] acc, acc_adj, bcd;
    logic [CW-1:0] cnt;
    logic valid, busy, done, start;
    generate
        if (DIGITS < (DATA_WIDTH * 30103 + 99999) / 100000) begin : g_digits_check
            $error("out_bcd_converter: DIGITS too small for DATA_WIDTH");
        end
    endgenerate
    assign start = bus.in != last_val;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= next;
    end
    always_comb begin
        next = state;
        case (state)
            IDLE: next = start ? SHIFT : IDLE;
            SHIFT: next = (cnt == CW'(DATA_WIDTH - 1)) ? DONE : SHIFT;
            default: next = IDLE;
        endcase
    end
    // Per-digit +3 correction; digits never carry into each other.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < DIGITS; i++)
            acc_adj[4*i+:4] = (acc[4*i+:4] >= 4'd5) ? acc[4*i+:4] + 4'd3 : acc[4*i+:4];
    end
`ifdef SEVEN_SEG_EN
    localparam logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b1111111, 7'b1111111,
        7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111
    };
    logic [7*DIGITS-1:0] seg;
    assign bus.seg = seg;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_val <= '0;
            shreg <= '0;
            acc <= '0;
            cnt <= '0;
            bcd <= '0;
            valid <= 1'b1;
            busy <= 1'b0;
            done <= 1'b0;
`ifdef SEVEN_SEG_EN
            seg <= {DIGITS{7'b1000000}};
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    last_val <= bus.in;
                    shreg <= bus.in;
                    acc <= '0;
                    cnt <= '0;
                    valid <= 1'b0;
                    busy <= 1'b1;
                end
                SHIFT: begin
                    {acc, shreg} <= {acc_adj, shreg} << 1;
                    cnt <= cnt + 1'b1;
                end
                default: begin
                    bcd <= acc;
                    done <= 1'b1;
                    valid <= 1'b1;
                    busy <= 1'b0;
`ifdef SEVEN_SEG_EN
                    for (int i = 0; i < DIGITS; i++) seg[7*i+:7] <= SEG[acc[4*i+:4]];
`endif
                end
            endcase
        end
    end
    assign bus.bcd = bcd;
    assign bus.valid = valid;
    assign bus.busy = busy;
    assign bus.done = done;
endmodule

// File: tb/tb_out_bcd_converter.sv
// tb_out_bcd_converter: randomized and directed stimulus; a monitor checks every done pulse
// against expected results queued from a decimal-arithmetic reference model.
module tb_out_bcd_converter;
    localparam int DW = 16;
    localparam int DG = 5;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    out_bcd_converter_if #(.DATA_WIDTH(DW), .DIGITS(DG)) bus ();
    out_bcd_converter #(.DATA_WIDTH(DW), .DIGITS(DG)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    logic [4*DG-1:0] exp_q[$];
    logic [4*DG-1:0] e;
    logic prev_done = 1'b0;
    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    function automatic logic [4*DG-1:0] to_bcd(int v);
        logic [4*DG-1:0] r;
        r = '0;
        for (int i = 0; i < DG; i++) begin
            r[4*i+:4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction
`ifdef SEVEN_SEG_EN
    function automatic logic [7*DG-1:0] to_seg(logic [4*DG-1:0] b);
        logic [6:0] tbl [10];
        logic [7*DG-1:0] r;
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        for (int i = 0; i < DG; i++) r[7*i+:7] = tbl[int'(b[4*i+:4])];
        return r;
    endfunction
`endif
    always @(negedge clk) begin
        chk("busy_valid_exclusive", 64'(bus.busy & bus.valid), 64'd0);
        chk("done_single_cycle", 64'(prev_done & bus.done), 64'd0);
        prev_done = bus.done;
        if (bus.done) begin
            done_cnt++;
            if (exp_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
            else begin
                e = exp_q.pop_front();
                chk("bcd", 64'(bus.bcd), 64'(e));
                chk("valid_at_done", 64'(bus.valid), 64'd1);
                chk("busy_at_done", 64'(bus.busy), 64'd0);
`ifdef SEVEN_SEG_EN
                chk("seg", 64'(bus.seg), 64'(to_seg(e)));
`endif
            end
        end
    end
    task automatic tick();
        @(negedge clk);
        #1;
    endtask
    task automatic wait_dones(int target);
        for (int i = 0; i < 200 && done_cnt < target; i++) tick();
        chk("done_timeout", 64'(done_cnt >= target), 64'd1);
    endtask
    task automatic check_reset_outputs(string tag);
        chk({tag, "_bcd"}, 64'(bus.bcd), 64'd0);
        chk({tag, "_valid"}, 64'(bus.valid), 64'd1);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_done"}, 64'(bus.done), 64'd0);
`ifdef SEVEN_SEG_EN
        chk({tag, "_seg"}, 64'(bus.seg), 64'({DG{7'b1000000}}));
`endif
    endtask
    // Applies one value and expects busy for exactly DW+1 sampled cycles before done.
    task automatic run_one(int v);
        int busy_n;
        int base;
        busy_n = 0;
        base = done_cnt;
        exp_q.push_back(to_bcd(v));
        bus.in = DW'(v);
        for (int i = 0; i < 100 && done_cnt == base; i++) begin
            tick();
            if (bus.busy) busy_n++;
        end
        chk("done_timeout", 64'(done_cnt - base), 64'd1);
        chk("busy_cycles", 64'(busy_n), 64'(DW + 1));
    endtask
    initial begin
        int v;
        int last;
        int base;
        bus.in = '0;
        tick();
        check_reset_outputs("rst_hold");
        rst_n = 1'b1;
        repeat (50) tick();
        check_reset_outputs("idle_zero");
        chk("no_done_idle", 64'(done_cnt), 64'd0);
        run_one(12345);
        run_one(65535);
        run_one(9);
        base = done_cnt;
        exp_q.push_back(to_bcd(100));
        exp_q.push_back(to_bcd(999));
        bus.in = DW'(100);
        repeat (6) tick();
        bus.in = DW'(999);
        wait_dones(base + 2);
        repeat (40) tick();
        chk("two_dones", 64'(done_cnt - base), 64'd2);
        bus.in = DW'(4321);
        repeat (9) tick();
        chk("busy_before_reset", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        tick();
        rst_n = 1'b1;
        exp_q.push_back(to_bcd(4321));
        wait_dones(done_cnt + 1);
        last = 4321;
`ifdef SEVEN_SEG_EN
        run_one(8080);
        chk("seg_8080", 64'(bus.seg),
            64'({7'b1000000, 7'b0000000, 7'b1000000, 7'b0000000, 7'b1000000}));
        last = 8080;
`endif
        for (int n = 0; n < 1000; n++) begin
            do v = int'($urandom_range(0, 65535)); while (v == last);
            run_one(v);
            last = v;
        end
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
